// File: rtl/ring_ctrl_pkg.sv
// Shared types and sizing helpers for the ring oscillator measurement sequencer.
package ring_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RING_RST,
        SETTLE,
        MEASURE,
        DONE
    } ring_meas_state_t;

    // One down-counter serves every timed state, so it must hold the largest reload value.
    function automatic int timer_w(input int gate_w, input int rst_cyc, input int settle_cyc);
        int w;
        w = gate_w;
        if ($clog2(rst_cyc) > w) w = $clog2(rst_cyc);
        if ($clog2(settle_cyc) > w) w = $clog2(settle_cyc);
        return w + 1;
    endfunction

endpackage

// File: rtl/ring_meas_ctrl_if.sv
// Control/readout bundle between system logic (master) and the measurement sequencer (slave).
interface ring_meas_ctrl_if #(
    parameter int CNT_W  = 24,
    parameter int GATE_W = 24
);
    logic              start;
    logic              abort;
    logic [GATE_W-1:0] gate_len;
    logic              osc_div;
    logic              ring_rst;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              ovf;

    modport master (
        output start, abort, gate_len, osc_div,
        input  ring_rst, busy, done, count, ovf
    );

    modport slave (
        input  start, abort, gate_len, osc_div,
        output ring_rst, busy, done, count, ovf
    );
endinterface

// File: rtl/ring_meas_ctrl_sync_edge.sv
// Two-flop synchronizer plus delay flop for an async ring tap; rise is high one clk cycle per edge.
// Latency: an input edge appears on rise two to three clk edges later; no backpressure.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= d;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;
endmodule

// File: rtl/ring_meas_ctrl.sv
// Resets the ring, waits for it to settle, then counts osc_div rising edges over gate_len clk cycles.
// Latency: done RST_CYC+SETTLE_CYC+gate_len cycles after start accept; start while busy is dropped.
module ring_meas_ctrl
    import ring_ctrl_pkg::*;
#(
    parameter int CNT_W      = 24,
    parameter int GATE_W     = 24,
    parameter int RST_CYC    = 16,
    parameter int SETTLE_CYC = 256
) (
    input logic            clk,
    input logic            rst,
    ring_meas_ctrl_if.slave bus
);
    localparam int               TW      = timer_w(GATE_W, RST_CYC, SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ring_meas_state_t  state_q;
    ring_meas_state_t  state_d;
    logic [TW-1:0]     timer_q;
    logic [TW-1:0]     timer_ld;
    logic [GATE_W-1:0] gate_q;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q;
    logic              osc_rise;
    logic              accept;

    sync_edge u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.osc_div),
        .rise (osc_rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Abort outranks every transition, including the MEASURE -> DONE step.
    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (bus.start && !bus.abort) state_d = RING_RST;
                RING_RST: if (timer_q == '0) state_d = SETTLE;
                SETTLE:   if (timer_q == '0) state_d = (gate_q == '0) ? DONE : MEASURE;
                MEASURE:  if (timer_q == '0) state_d = DONE;
                DONE:     state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ring_rst = 1'b1;
        bus.busy     = (state_q != IDLE);
        bus.done     = 1'b0;
        case (state_q)
            SETTLE, MEASURE: bus.ring_rst = 1'b0;
            DONE:            bus.done     = 1'b1;
            default:         bus.ring_rst = 1'b1;
        endcase
    end

    // Reload holds N-1 so that a state lasts exactly N cycles before the timer hits zero.
    always_comb begin
        timer_ld = '0;
        case (state_d)
            RING_RST: timer_ld = TW'(RST_CYC - 1);
            SETTLE:   timer_ld = TW'(SETTLE_CYC - 1);
            MEASURE:  timer_ld = TW'(gate_q) - TW'(1);
            default:  timer_ld = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= '0;
        end else if (state_d != state_q) begin
            timer_q <= timer_ld;
        end else if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
        end
    end

    assign accept = (state_q == IDLE) && (state_d == RING_RST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            gate_q  <= bus.gate_len;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (state_q == MEASURE && !bus.abort && osc_rise) begin
            if (count_q == CNT_MAX) ovf_q   <= 1'b1;
            else                    count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_ring_meas_ctrl.sv
// Directed bench for ring_meas_ctrl with RST_CYC=4, SETTLE_CYC=8; a second 4-bit instance covers saturation.
module tb_ring_meas_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks  = 0;
    int   errors  = 0;
    int   gcyc    = 0;
    int   osc_per = 0;
    int   ndone;

    always #5 clk = ~clk;

    ring_meas_ctrl_if #(.CNT_W(24), .GATE_W(24)) bus  ();
    ring_meas_ctrl_if #(.CNT_W(4),  .GATE_W(24)) bus4 ();

    ring_meas_ctrl #(.CNT_W(24), .GATE_W(24), .RST_CYC(4), .SETTLE_CYC(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    ring_meas_ctrl #(.CNT_W(4), .GATE_W(24), .RST_CYC(4), .SETTLE_CYC(8)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives osc_div for the current cycle, then advances to 1ns after the next rising edge.
    task automatic tick();
        logic o;
        o = (osc_per != 0) && ((gcyc % osc_per) >= osc_per / 2);
        bus.osc_div  = o;
        bus4.osc_div = o;
        @(posedge clk);
        #1;
        gcyc++;
    endtask

    task automatic run_basic(input string tag);
        chk({tag, ".idle_busy"}, bus.busy, 0);
        bus.gate_len = 100;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 115; c++) begin
            chk({tag, ".ring_rst"}, bus.ring_rst, (c < 5 || c >= 113));
            chk({tag, ".done"},     bus.done,     (c == 113));
            chk({tag, ".busy"},     bus.busy,     (c <= 113));
            if (c == 113) begin
                chk({tag, ".count"}, bus.count, 10);
                chk({tag, ".ovf"},   bus.ovf,   0);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.start = 1'b0;  bus.abort = 1'b0;  bus.gate_len = '0;  bus.osc_div = 1'b0;
        bus4.start = 1'b0; bus4.abort = 1'b0; bus4.gate_len = '0; bus4.osc_div = 1'b0;
        tick();
        tick();
        chk("rst.ring_rst", bus.ring_rst, 1);
        chk("rst.busy",     bus.busy,     0);
        chk("rst.done",     bus.done,     0);
        chk("rst.count",    bus.count,    0);
        chk("rst.ovf",      bus.ovf,      0);
        rst = 1'b1;
        osc_per = 10;
        repeat (4) tick();

        // Basic 100-cycle gate, 10-cycle oscillator period
        run_basic("basic");

        // Zero gate skips MEASURE entirely
        bus.gate_len = 0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            chk("zero.ring_rst", bus.ring_rst, (c < 5 || c >= 13));
            chk("zero.done",     bus.done,     (c == 13));
            if (c == 13) chk("zero.count", bus.count, 0);
            tick();
        end

        // Saturation on the 4-bit instance: 25 edges in a 200-cycle gate
        osc_per = 8;
        bus4.gate_len = 200;
        bus4.start    = 1'b1;
        tick();
        bus4.start = 1'b0;
        for (int c = 1; c <= 215; c++) begin
            chk("sat.done", bus4.done, (c == 213));
            if (c == 213) begin
                chk("sat.count", bus4.count, 15);
                chk("sat.ovf",   bus4.ovf,   1);
            end
            tick();
        end
        bus4.gate_len = 0;
        bus4.start    = 1'b1;
        tick();
        bus4.start = 1'b0;
        chk("sat.ovf_clear",   bus4.ovf,   0);
        chk("sat.count_clear", bus4.count, 0);
        repeat (16) tick();

        // Abort at cycle 50: rises land on cycles 17,27,37,47 of MEASURE
        osc_per = 10;
        while (gcyc % 10 != 0) tick();
        bus.gate_len = 100;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 50; c++) begin
            chk("abort.pre_done", bus.done, 0);
            tick();
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort.busy",     bus.busy,     0);
        chk("abort.ring_rst", bus.ring_rst, 1);
        chk("abort.done",     bus.done,     0);
        chk("abort.count",    bus.count,    4);
        for (int c = 52; c <= 120; c++) begin
            chk("abort.no_done", bus.done, 0);
            tick();
        end
        chk("abort.count_hold", bus.count, 4);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort.start_idle", bus.busy, 0);

        // Start while busy and start during DONE are both dropped
        bus.gate_len = 100;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy.count_clear", bus.count, 0);
        ndone = 0;
        for (int c = 1; c <= 116; c++) begin
            chk("busy.done", bus.done, (c == 113));
            chk("busy.busy", bus.busy, (c <= 113));
            if (bus.done === 1'b1) ndone++;
            if (c == 113) chk("busy.count", bus.count, 10);
            bus.start = (c == 20 || c == 113);
            if (c == 20) bus.gate_len = 5;
            tick();
        end
        bus.start = 1'b0;
        chk("busy.ndone", ndone, 1);

        // Async reset in the middle of MEASURE
        bus.gate_len = 100;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 60; c++) tick();
        chk("mid.busy_before", bus.busy, 1);
        rst = 1'b0;
        #1;
        chk("mid.ring_rst", bus.ring_rst, 1);
        chk("mid.busy",     bus.busy,     0);
        chk("mid.done",     bus.done,     0);
        chk("mid.count",    bus.count,    0);
        chk("mid.ovf",      bus.ovf,      0);
        repeat (3) tick();
        rst = 1'b1;
        for (int c = 0; c < 60; c++) begin
            chk("mid.no_done", bus.done, 0);
            chk("mid.idle",    bus.busy, 0);
            tick();
        end
        run_basic("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ring_meas_ctrl.md
Name: ring_meas_ctrl

Overview:
Synchronous sequencer that owns the ring oscillator's reset and measures its frequency.
- On a start request it holds the ring in reset for a fixed time, releases it, and waits a settle window.
- It then counts rising edges of the divided ring output over a programmable gate of clk cycles and reports the count with a done pulse.
- Sits between ring/prescaler logic (async side) and system control/readout (clk side).

Parameters:
CNT_W, 24, width of edge counter / count output
GATE_W, 24, width of gate_len
RST_CYC, 16, clk cycles ring_rst is held high after start (>=1)
SETTLE_CYC, 256, clk cycles after ring release before counting (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  measurement request, sampled in IDLE only
abort  in  1  cancel measurement, return to IDLE, no done
gate_len  in  GATE_W  measurement window in clk cycles, latched on start accept
osc_div  in  1  divided ring output (async to clk); toggle rate guaranteed < clk/4
ring_rst  out  1  active-high reset to ring and ODDR
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse, count valid
count  out  CNT_W  rising edges of osc_div seen in gate
ovf  out  1  count saturated during last measurement

Behaviour:
- Reset (rst low) values:
  - outputs: state=IDLE, ring_rst=1, busy=0, done=0, count=0, ovf=0.
  - internal: sync flops=0, timers=0.
- FSM states: IDLE, RING_RST, SETTLE, MEASURE, DONE.
- IDLE:
  - ring_rst=1, ring parked.
  - start=1 at edge k: latch gate_len, clear count/ovf, enter RING_RST at k+1.
  - start while busy is ignored, not queued.
- RING_RST: ring_rst=1 for exactly RST_CYC cycles, then SETTLE.
- SETTLE: ring_rst=0 for exactly SETTLE_CYC cycles, then MEASURE; if latched gate_len==0, go directly to DONE.
- MEASURE:
  - ring_rst=0 for exactly latched gate_len cycles.
  - each cycle with a synchronized rising edge of osc_div increments count.
  - an edge detected in the last MEASURE cycle is counted.
  - edges detected in SETTLE or DONE are not counted.
- DONE:
  - one cycle; done=1, ring_rst=1, busy=1; next state IDLE.
  - count and ovf hold until the next accepted start.
- Latency: done asserted at edge k+1+RST_CYC+SETTLE_CYC+gate_len; for gate_len=0, k+1+RST_CYC+SETTLE_CYC.
- osc_div path: 2-flop synchronizer plus one delay flop; rise = q & ~q_d. Synchronizer runs in all states, so no false edge at MEASURE entry.
- Saturation: count stops at 2^CNT_W-1; a further edge sets ovf=1; no wrap.
- abort:
  - In any non-IDLE state: next cycle IDLE, ring_rst=1, done never pulses, count holds partial value.
  - abort has priority over all transitions, including the DONE entry in the same cycle.
  - abort together with start in IDLE: start ignored.
- Async reset mid-measurement: immediate return to reset values; no done.
- Timer: a single down-counter sized max(GATE_W, clog2(RST_CYC), clog2(SETTLE_CYC))+1, reloaded on each state entry.

Decomposition:
- ring_ctrl_pkg: state enum (IDLE, RING_RST, SETTLE, MEASURE, DONE) as typedef ring_meas_state_t; timer width helper function.
- Sub-module sync_edge: parameterless 2-flop synchronizer plus rising-edge detector with async active-low reset; reusable for other async ring taps.

Test Plan:
All tests use RST_CYC=4, SETTLE_CYC=8.
1. Basic: gate_len=100, osc_div period 10 clk, start pulse at cycle 0 -> ring_rst high cycles 1-4, low 5-112; done at cycle 113; count=10, ovf=0.
2. Zero gate: gate_len=0, osc_div toggling -> done at cycle 13, count=0, ring_rst never low during a MEASURE state.
3. Saturation: CNT_W=4, gate_len=200, osc_div period 8 -> count=15, ovf=1 at done.
4. Abort: gate_len=100, abort at cycle 50 -> IDLE at 51, ring_rst=1 at 51, no done pulse, count equals edges counted before 51; a subsequent start clears count.
5. Start while busy: second start at cycle 20 -> ignored, single done at 113; start in DONE cycle is also ignored.
6. Reset mid-run: rst low at cycle 60 for 3 cycles -> all outputs at reset values immediately; no done; new start after release behaves as in test 1.
